heap_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 32-bit max-heap engine (start/instruction/key/done handshake) between NUM_REQ requesters.
- Accepts one push or pop request at a time and issues it to the heap engine.
- Waits for the engine's completion, tracks occupancy and the current maximum, and returns a per-requester response.
- Rejects illegal operations locally, without issuing them to the engine.

---
 rtl/heap_arbiter_if.sv | 39 +++
 rtl/heap_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/heap_arbiter_if.sv
`timescale 1ns/1ps
// heap_arbiter_if: requester, engine and status signals of the heap arbiter.
// The slave modport is the arbiter's view. The master modport is the
// surrounding logic: the requesters plus the heap engine.
interface heap_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_key;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic                  resp_err;
  logic [31:0]           resp_key;

  // Heap engine side
  logic                  heap_start;
  logic [1:0]            heap_instr;
  logic [31:0]           heap_key;
  logic                  heap_done;
  logic [31:0]           heap_arr_out;

  // Status
  logic [10:0]           occupancy;
  logic                  fault;

  modport slave (
    input  req_valid, req_op, req_key, heap_done, heap_arr_out,
    output req_ready, resp_valid, resp_err, resp_key,
           heap_start, heap_instr, heap_key, occupancy, fault
  );

  modport master (
    output req_valid, req_op, req_key, heap_done, heap_arr_out,
    input  req_ready, resp_valid, resp_err, resp_key,
           heap_start, heap_instr, heap_key, occupancy, fault
  );
endinterface

// File: rtl/heap_arbiter.sv
`timescale 1ns/1ps
// heap_arbiter: round-robin front end that shares one max-heap engine
// between NUM_REQ requesters. Only one transaction is in flight at a time.
// Illegal opcodes, pop on an empty heap and push on a full heap are
// answered locally and never reach the engine. Occupancy and the current
// maximum are tracked here. A missing heap_done sets a sticky fault, and
// no further grants are made until reset.
module heap_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  heap_arbiter_if.slave bus
);
  // State   | Meaning
  // IDLE    | arbitrate among pending requests, pulse req_ready, pre-check op
  // ISSUE   | pulse heap_start, load the timeout counter
  // WAIT    | wait for heap_done; update count, or time out into fault
  // CAPTURE | keep the old max as pop result, load the new root
  // RESP    | pulse resp_valid to the granted requester, advance rr pointer
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0]         OP_PUSH  = 2'b01;
  localparam logic [1:0]         OP_POP   = 2'b10;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [10:0]        DEPTH_C  = 11'(DEPTH);
  localparam logic [TW-1:0]      TMO_LOAD = TW'(TIMEOUT - 1);

  state_t               state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        gnt_q;
  logic [1:0]           op_q;
  logic [31:0]          key_q;
  logic                 err_q;
  logic [TW-1:0]        wait_cnt_q;
  logic [10:0]          count_q;
  logic [31:0]          top_key_q;
  logic [31:0]          pop_res_q;

  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic                 resp_err_q;
  logic [31:0]          resp_key_q;
  logic                 heap_start_q;
  logic [1:0]           heap_instr_q;
  logic [31:0]          heap_key_q;
  logic                 fault_q;

  logic                 gnt_found_d;
  logic [PW-1:0]        gnt_idx_d;
  logic [1:0]           gnt_op_d;
  logic [31:0]          gnt_key_d;
  logic                 gnt_reject_d;

  // Requester index at a given offset above base, wrapping at NUM_REQ.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Find the first pending requester at or above rr_ptr. The loop runs
  // downward so that the smallest offset is written last and wins.
  always_comb begin
    gnt_found_d = 1'b0;
    gnt_idx_d   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[rr_idx(rr_ptr_q, i)]) begin
        gnt_found_d = 1'b1;
        gnt_idx_d   = rr_idx(rr_ptr_q, i);
      end
    end
  end

  // Opcode and key of the candidate, and the local legality check.
  always_comb begin
    gnt_op_d     = bus.req_op[{gnt_idx_d, 1'b0} +: 2];
    gnt_key_d    = bus.req_key[{gnt_idx_d, 5'b0} +: 32];
    gnt_reject_d = ((gnt_op_d != OP_PUSH) && (gnt_op_d != OP_POP)) ||
                   ((gnt_op_d == OP_POP)  && (count_q == 11'd0)) ||
                   ((gnt_op_d == OP_PUSH) && (count_q == DEPTH_C));
  end

  // Sequencer FSM. All outputs are registered here; the pulses clear every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      op_q         <= '0;
      key_q        <= '0;
      err_q        <= 1'b0;
      wait_cnt_q   <= '0;
      count_q      <= '0;
      top_key_q    <= '0;
      pop_res_q    <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_key_q   <= '0;
      heap_start_q <= 1'b0;
      heap_instr_q <= '0;
      heap_key_q   <= '0;
      fault_q      <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      heap_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          resp_err_q <= 1'b0;
          resp_key_q <= '0;
          if (!fault_q && gnt_found_d) begin
            req_ready_q <= ONE_HOT0 << gnt_idx_d;
            gnt_q       <= gnt_idx_d;
            op_q        <= gnt_op_d;
            key_q       <= gnt_key_d;
            if (gnt_reject_d) begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else begin
              err_q        <= 1'b0;
              heap_instr_q <= gnt_op_d;
              heap_key_q   <= gnt_key_d;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          heap_start_q <= 1'b1;
          wait_cnt_q   <= TMO_LOAD;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // heap_done wins over expiry on the last allowed cycle.
          if (bus.heap_done) begin
            count_q      <= (op_q == OP_PUSH) ? count_q + 11'd1 : count_q - 11'd1;
            heap_instr_q <= '0;
            heap_key_q   <= '0;
            state_q      <= S_CAPTURE;
          end else if (wait_cnt_q == '0) begin
            fault_q      <= 1'b1;
            err_q        <= 1'b1;
            heap_instr_q <= '0;
            heap_key_q   <= '0;
            state_q      <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        S_CAPTURE: begin
          // count_q already holds the post-op count here.
          pop_res_q <= top_key_q;
          top_key_q <= (count_q != 11'd0) ? bus.heap_arr_out : 32'd0;
          state_q   <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= ONE_HOT0 << gnt_q;
          resp_err_q   <= err_q;
          resp_key_q   <= err_q ? 32'd0 : ((op_q == OP_PUSH) ? key_q : pop_res_q);
          rr_ptr_q     <= rr_idx(gnt_q, 1);
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_key   = resp_key_q;
  assign bus.heap_start = heap_start_q;
  assign bus.heap_instr = heap_instr_q;
  assign bus.heap_key   = heap_key_q;
  assign bus.occupancy  = count_q;
  assign bus.fault      = fault_q;
endmodule
